// File: rtl/multich_onedconv_ctrl.sv
// multich_onedconv_ctrl: sequencer for a multi-channel 1-D convolution row.
// Walks output columns (base), input channels (c) and kernel taps (k),
// issuing one MAC per cycle with row-buffer/weight addresses and strobes.
// Optional feature: define MCONV_PADDING_EN to add symmetric zero padding
// (MCONV_Pad input, MCONV_Zero_Pad output).
module multich_onedconv_ctrl #(
  parameter int BITWIDTH_COLS   = 11,
  parameter int BITWIDTH_W      = 4,
  parameter int BITWIDTH_STRIDE = 4,
  parameter int BITWIDTH_CH     = 4
) (
  input  logic                       MCONV_Clk,
  input  logic                       MCONV_Reset,
  input  logic                       MCONV_Start,
  input  logic                       MCONV_Stall,
  input  logic [BITWIDTH_COLS-1:0]   MCONV_If_Colums,
  input  logic [BITWIDTH_W-1:0]      MCONV_W_Colums,
  input  logic [BITWIDTH_STRIDE-1:0] MCONV_Conv_Stride,
  input  logic [BITWIDTH_CH-1:0]     MCONV_Channels,
`ifdef MCONV_PADDING_EN
  input  logic [BITWIDTH_W-1:0]      MCONV_Pad,
  output logic                       MCONV_Zero_Pad,
`endif
  output logic                       MCONV_Busy,
  output logic                       MCONV_Err,
  output logic                       MCONV_Rptclr,
  output logic                       MCONV_Wptclr,
  output logic                       MCONV_Mac_En,
  output logic                       MCONV_Acc_Clr,
  output logic [BITWIDTH_COLS-1:0]   MCONV_Rd_Addr,
  output logic [BITWIDTH_W-1:0]      MCONV_W_Addr,
  output logic [BITWIDTH_CH-1:0]     MCONV_Ch,
  output logic                       MCONV_O_En,
  output logic [BITWIDTH_COLS-1:0]   MCONV_O_Col,
  output logic                       MCONV_Done
);

  // Signed width for base (can go negative by Pad) and for base+S+W sums.
  localparam int BW = BITWIDTH_COLS + 2;
  localparam int AW = BITWIDTH_COLS + 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                      r_state;
  logic [BITWIDTH_COLS-1:0]    r_if;
  logic [BITWIDTH_W-1:0]       r_w;
  logic [BITWIDTH_STRIDE-1:0]  r_s;
  logic [BITWIDTH_CH-1:0]      r_ch;
  logic [BITWIDTH_W-1:0]       r_pad;
  logic signed [BW-1:0]        r_base;
  logic [BITWIDTH_W-1:0]       r_k;
  logic [BITWIDTH_CH-1:0]      r_c;
  logic [BITWIDTH_COLS-1:0]    r_oc;
  logic                        r_pend;  // a column finished on the previous MAC

  logic                        r_busy, r_err, r_rptclr, r_wptclr, r_mac_en;
  logic                        r_acc_clr, r_o_en, r_done;
  logic [BITWIDTH_COLS-1:0]    r_rd_addr, r_o_col;
  logic [BITWIDTH_W-1:0]       r_w_addr;
  logic [BITWIDTH_CH-1:0]      r_ch_idx;
`ifdef MCONV_PADDING_EN
  logic                        r_zero_pad;
`endif

  logic [BITWIDTH_W-1:0]       w_pad_in;
  logic                        w_cfg_ok;
  logic signed [AW-1:0]        w_addr, w_next_end, w_limit;
  logic                        w_oob, w_more, w_last_k, w_last_c;

`ifdef MCONV_PADDING_EN
  assign w_pad_in       = MCONV_Pad;
  assign MCONV_Zero_Pad = r_zero_pad;
`else
  assign w_pad_in = '0;
`endif

  // Kernel must be non-empty and fit inside the (padded) row.
  assign w_cfg_ok = (MCONV_W_Colums != '0) && (MCONV_Conv_Stride != '0) &&
                    (MCONV_Channels != '0) &&
                    (AW'(MCONV_W_Colums) <=
                     AW'(MCONV_If_Colums) + AW'(w_pad_in) + AW'(w_pad_in));

  // Virtual column base+k; anything left of 0 or right of the row is padding.
  assign w_addr     = AW'(r_base) + AW'(r_k);
  assign w_oob      = w_addr[AW-1] || (w_addr >= $signed(AW'(r_if)));
  assign w_next_end = AW'(r_base) + AW'(r_s) + AW'(r_w);
  assign w_limit    = AW'(r_if) + AW'(r_pad);
  assign w_more     = (w_next_end <= w_limit);
  assign w_last_k   = (r_k == r_w - 1'b1);
  assign w_last_c   = (r_c == r_ch - 1'b1);

  assign MCONV_Busy    = r_busy;
  assign MCONV_Err     = r_err;
  assign MCONV_Rptclr  = r_rptclr;
  assign MCONV_Wptclr  = r_wptclr;
  assign MCONV_Mac_En  = r_mac_en;
  assign MCONV_Acc_Clr = r_acc_clr;
  assign MCONV_Rd_Addr = r_rd_addr;
  assign MCONV_W_Addr  = r_w_addr;
  assign MCONV_Ch      = r_ch_idx;
  assign MCONV_O_En    = r_o_en;
  assign MCONV_O_Col   = r_o_col;
  assign MCONV_Done    = r_done;

  // Control FSM: config latch, k/c/base counters and all registered outputs.
  // NOTE: every state register uses <= so all updates see pre-edge values;
  // the async reset clears them so an abort never leaves a half-finished job.
  always_ff @(posedge MCONV_Clk or posedge MCONV_Reset) begin
    if (MCONV_Reset) begin
      r_state   <= S_IDLE;
      r_if      <= '0;
      r_w       <= '0;
      r_s       <= '0;
      r_ch      <= '0;
      r_pad     <= '0;
      r_base    <= '0;
      r_k       <= '0;
      r_c       <= '0;
      r_oc      <= '0;
      r_pend    <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_rptclr  <= 1'b0;
      r_wptclr  <= 1'b0;
      r_mac_en  <= 1'b0;
      r_acc_clr <= 1'b0;
      r_rd_addr <= '0;
      r_w_addr  <= '0;
      r_ch_idx  <= '0;
      r_o_en    <= 1'b0;
      r_o_col   <= '0;
      r_done    <= 1'b0;
`ifdef MCONV_PADDING_EN
      r_zero_pad <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low every cycle.
      r_err     <= 1'b0;
      r_rptclr  <= 1'b0;
      r_wptclr  <= 1'b0;
      r_mac_en  <= 1'b0;
      r_acc_clr <= 1'b0;
      r_o_en    <= 1'b0;
      r_done    <= 1'b0;
      r_pend    <= 1'b0;

      // Column completion is reported one cycle after its last MAC,
      // regardless of Stall.
      if (r_pend) begin
        r_o_en  <= 1'b1;
        r_o_col <= r_oc;
        r_oc    <= r_oc + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_busy <= 1'b0;
          // Busy is still high for the cycle Done is shown; Start is ignored then.
          if (MCONV_Start && !r_busy) begin
            if (w_cfg_ok) begin
              r_if     <= MCONV_If_Colums;
              r_w      <= MCONV_W_Colums;
              r_s      <= MCONV_Conv_Stride;
              r_ch     <= MCONV_Channels;
              r_pad    <= w_pad_in;
              r_base   <= -$signed(BW'(w_pad_in));
              r_k      <= '0;
              r_c      <= '0;
              r_oc     <= '0;
              r_busy   <= 1'b1;
              r_rptclr <= 1'b1;
              r_state  <= S_RUN;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        S_RUN: begin
          if (!MCONV_Stall) begin
            r_mac_en  <= 1'b1;
            r_rd_addr <= w_oob ? '0 : w_addr[BITWIDTH_COLS-1:0];
            r_w_addr  <= r_k;
            r_ch_idx  <= r_c;
            r_wptclr  <= (r_k == '0);
            r_acc_clr <= (r_k == '0) && (r_c == '0);
`ifdef MCONV_PADDING_EN
            r_zero_pad <= w_oob;
`endif
            if (w_last_k) begin
              r_k <= '0;
              if (!w_last_c) begin
                r_c <= r_c + 1'b1;
              end else begin
                r_c    <= '0;
                r_pend <= 1'b1;
                if (w_more) r_base  <= r_base + $signed(BW'(r_s));
                else        r_state <= S_DONE;
              end
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end

        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multich_onedconv_ctrl.sv
// tb_multich_onedconv_ctrl: directed and randomized jobs for the 1-D conv
// controller, compared against a loop-based model of the MAC schedule.
module tb_multich_onedconv_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stall;
  logic [10:0] if_cols;
  logic [3:0]  w_cols, stride, chans, pad_in;
  logic        busy, err, rptclr, wptclr, mac_en, acc_clr, o_en, done;
  logic [10:0] rd_addr, o_col;
  logic [3:0]  w_addr_o, ch_o;
  logic        zp_obs;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [10:0] rd;
    logic [3:0]  wa;
    logic [3:0]  ch;
    logic        wpt;
    logic        acc;
    logic        zp;
  } mac_t;

  always #5 clk = ~clk;

  multich_onedconv_ctrl dut (
    .MCONV_Clk        (clk),
    .MCONV_Reset      (rst),
    .MCONV_Start      (start),
    .MCONV_Stall      (stall),
    .MCONV_If_Colums  (if_cols),
    .MCONV_W_Colums   (w_cols),
    .MCONV_Conv_Stride(stride),
    .MCONV_Channels   (chans),
`ifdef MCONV_PADDING_EN
    .MCONV_Pad        (pad_in),
    .MCONV_Zero_Pad   (zp_obs),
`endif
    .MCONV_Busy       (busy),
    .MCONV_Err        (err),
    .MCONV_Rptclr     (rptclr),
    .MCONV_Wptclr     (wptclr),
    .MCONV_Mac_En     (mac_en),
    .MCONV_Acc_Clr    (acc_clr),
    .MCONV_Rd_Addr    (rd_addr),
    .MCONV_W_Addr     (w_addr_o),
    .MCONV_Ch         (ch_o),
    .MCONV_O_En       (o_en),
    .MCONV_O_Col      (o_col),
    .MCONV_Done       (done)
  );

`ifndef MCONV_PADDING_EN
  assign zp_obs = 1'b0;
`endif

  function automatic logic [63:0] all_outs();
    return 64'({busy, err, rptclr, wptclr, mac_en, acc_clr, rd_addr, w_addr_o,
                ch_o, o_en, o_col, done, zp_obs});
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one valid job and checks it against the schedule model.
  // mode: 0 no stall, 1 random stall, 2 three-cycle stall after the 4th MAC.
  task automatic run_job(input int ifc, input int w, input int s, input int ch,
                         input int p, input int mode, input bit poke_start);
    mac_t exp_q[$];
    mac_t m, got;
    int   a, n_exp, oc_exp, n_mac, n_oen, n_stall, n_rpt, t, budget, stall_left;
    bit   done_seen, stalled_once;

    // Model: slide the window over the padded row; per window, every channel,
    // every tap. Padded positions read address 0 and flag zero padding.
    exp_q = {};
    for (int b = -p; b + w <= ifc + p; b += s) begin
      for (int c = 0; c < ch; c++) begin
        for (int k = 0; k < w; k++) begin
          a     = b + k;
          m.zp  = (a < 0) || (a >= ifc);
          m.rd  = m.zp ? 11'd0 : 11'(a);
          m.wa  = 4'(k);
          m.ch  = 4'(c);
          m.wpt = (k == 0);
          m.acc = (k == 0) && (c == 0);
          exp_q.push_back(m);
        end
      end
    end
    oc_exp = (ifc + 2 * p - w) / s + 1;
    n_exp  = oc_exp * ch * w;
    budget = 4 * n_exp + 40;

    @(negedge clk);
    if_cols = 11'(ifc); w_cols = 4'(w); stride = 4'(s); chans = 4'(ch); pad_in = 4'(p);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("busy_on", busy, 1);
    check("rptclr_on_start", {rptclr, mac_en, err}, 3'b100);
    // Later config changes must not disturb the running job.
    if_cols = 11'($urandom); w_cols = 4'($urandom); stride = 4'($urandom);
    chans = 4'($urandom); pad_in = 4'($urandom);

    n_mac = 0; n_oen = 0; n_stall = 0; n_rpt = 0; t = 0; stall_left = 0;
    done_seen = 1'b0; stalled_once = 1'b0;
    while (!done_seen && t < budget) begin
      if (mode == 1) begin
        stall = ($urandom_range(3, 0) == 0);
      end else if (mode == 2) begin
        if (n_mac == 4 && !stalled_once) begin
          stall_left = 3; stalled_once = 1'b1;
        end
        stall = (stall_left > 0);
        if (stall_left > 0) stall_left--;
      end else begin
        stall = 1'b0;
      end
      if (stall && n_mac < n_exp) n_stall++;
      if (poke_start) start = (t == 5);
      @(posedge clk);
      t++;
      @(negedge clk);
      if (rptclr) n_rpt++;
      if (mac_en) begin
        got.rd = rd_addr; got.wa = w_addr_o; got.ch = ch_o;
        got.wpt = wptclr; got.acc = acc_clr; got.zp = zp_obs;
        if (n_mac < n_exp) check($sformatf("mac%0d", n_mac), got, exp_q[n_mac]);
        n_mac++;
      end else if (stall && n_mac > 0 && n_mac < n_exp) begin
        check("stall_hold", {rd_addr, w_addr_o, ch_o},
              {exp_q[n_mac-1].rd, exp_q[n_mac-1].wa, exp_q[n_mac-1].ch});
      end
      if (o_en) begin
        check("o_col", o_col, n_oen);
        n_oen++;
      end
      if (done) begin
        done_seen = 1'b1;
        check("done_with_last_oen", {o_en, o_col}, {1'b1, 11'(oc_exp - 1)});
      end
    end
    stall = 1'b0;
    start = 1'b0;
    check("done_seen", done_seen, 1);
    check("mac_count", n_mac, n_exp);
    check("col_count", n_oen, oc_exp);
    // Done is visible after edge N+1+stalls, captured downstream at N+2+stalls.
    check("latency", t, n_exp + 1 + n_stall);
    check("no_extra_rptclr", n_rpt, 0);
    @(negedge clk);
    check("busy_off", {busy, mac_en, done}, 3'b000);
  endtask

  // Start with an invalid configuration: Err pulse only, nothing starts.
  task automatic run_bad(input int ifc, input int w, input int s, input int ch);
    logic any;
    @(negedge clk);
    if_cols = 11'(ifc); w_cols = 4'(w); stride = 4'(s); chans = 4'(ch); pad_in = 4'd0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("err_pulse", {err, busy, rptclr, mac_en}, 4'b1000);
    any = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any = any | err | busy | rptclr | mac_en;
    end
    check("err_quiet", any, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stall = 1'b0;
    if_cols = '0; w_cols = '0; stride = '0; chans = '0; pad_in = '0;
    #2;
    check("reset_outs", all_outs(), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("post_reset_outs", all_outs(), 64'd0);

    // T1 / T2 / T3
    run_job(6, 2, 1, 1, 0, 0, 1'b0);
    run_job(7, 3, 2, 2, 0, 0, 1'b0);
    run_job(7, 3, 2, 2, 0, 2, 1'b1);

    // T4: W wider than the row, then zero stride, then a normal job.
    run_bad(4, 5, 1, 1);
    run_bad(6, 2, 0, 1);
    run_job(6, 2, 1, 1, 0, 0, 1'b0);

    // T5: asynchronous abort mid-job, then T1 again.
    @(negedge clk);
    if_cols = 11'd6; w_cols = 4'd2; stride = 4'd1; chans = 4'd1; pad_in = 4'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("abort_outs", all_outs(), 64'd0);
    @(negedge clk);
    check("abort_hold", all_outs(), 64'd0);
    rst = 1'b0;
    run_job(6, 2, 1, 1, 0, 0, 1'b0);

    // Randomized jobs with random stalls.
    for (int i = 0; i < 6; i++) begin
      int ifc, w, s, ch;
      ifc = $urandom_range(24, 1);
      w   = $urandom_range((ifc < 15) ? ifc : 15, 1);
      s   = $urandom_range(15, 1);
      ch  = $urandom_range(3, 1);
      run_job(ifc, w, s, ch, 0, 1, 1'b0);
    end

`ifdef MCONV_PADDING_EN
    // T6: padded row.
    run_job(4, 3, 1, 1, 1, 0, 1'b0);
    run_job(5, 3, 2, 2, 2, 1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
